scs8hd_norbb_pipe: RTL and testbench
====================================

// Module: scs8hd_norbb_pipe
// PURPOSE
//  Multi-channel, parametrised NOR-with-inverted-inputs function: per channel Y = ~|A & (&BN).
//  Widens the 4-input nor/and-bb cell function to CH channels of NA true and NB inverted inputs.
//  Adds a registered valid/ready stage with a 2-entry skid buffer for use in pipelined datapaths.
//  Sits between sample producers and decode/control logic that need backpressure.
// PARAMETERS
//  CH     4  number of independent channels
//  NA     2  true (NOR-ed) inputs per channel, >=1
//  NB     2  inverted (AND-ed) inputs per channel, >=1
//  CNT_W  8  width of per-channel hit counters (optional feature only), >=1
// PORTS
//  CLK        in   1         clock, all state on rising edge
//  RESET      in   1         asynchronous, active-high reset
//  IN_VALID   in   1         input sample valid
//  IN_READY   out  1         buffer can accept; registered, = (occupancy != FULL)
//  A          in   CH*NA     true inputs, channel c at [c*NA +: NA]
//  BN         in   CH*NB     inverted inputs, channel c at [c*NB +: NB]
//  OUT_VALID  out  1         head entry valid
//  OUT_READY  in   1         consumer accepts head
//  Y          out  CH        head entry result per channel; 0 when OUT_VALID=0
//  ANY_Y      out  1         |Y (gated by OUT_VALID)
//  CNT_CLR    in   1         synchronous clear of hit counters
//  HIT_CNT    out  CH*CNT_W  per-channel saturating hit counts
// BEHAVIOUR
//  - Function: y[c] = ~(|A[c]) & (&BN[c]), computed combinationally on push, stored as CH bits.
//  - Push = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY. Storage is a 2-entry FIFO, in order.
//  - Latency 1: sample pushed at edge k appears on Y with OUT_VALID=1 after edge k.
//  - Throughput 1/cycle while OUT_READY=1; IN_VALID may be held without loss.
//  - Occupancy FSM EMPTY/ONE/FULL: push&!pop +1; pop&!push -1; push&pop holds (ONE stays ONE,
//    EMPTY cannot pop, FULL cannot push since IN_READY=0). No state skips a level.
//  - FULL: IN_READY=0 next cycle; pop in FULL -> ONE, IN_READY=1 after that edge.
//  - Inputs ignored when IN_VALID=0 or IN_READY=0; Y stable while OUT_VALID&!OUT_READY.
//  - Reset (any time, incl. mid-transfer): occupancy EMPTY, OUT_VALID=0, Y=0, ANY_Y=0,
//    IN_READY=0 while RESET high, 1 on first edge after release; HIT_CNT=0; contents discarded.
// CONFIGURATION
//  SCS8HD_NORBB_HITCNT_EN defined: per-channel counter increments on each pop where Y[c]=1,
//    saturates at 2**CNT_W-1 (no wrap); CNT_CLR has priority over increment, clears same edge.
//  Not defined: no counter flops; HIT_CNT tied to 0; CNT_CLR ignored.
// STRUCTURE
//  Package scs8hd_norbb_pkg: occupancy enum (EMPTY/ONE/FULL), function norbb_eval(a,bn)
//    returning one channel's y, localparam for saturation value derivation.
//  Sub-module scs8hd_norbb_skid: generic 2-entry valid/ready skid buffer, width parameter,
//    holds the occupancy FSM; top instantiates it with width CH and adds eval + counters.
// TESTING
//  1 Reset: assert RESET mid-stream with 2 entries held -> OUT_VALID=0, Y=0, HIT_CNT=0 at once;
//    IN_READY=1 one edge after release.
//  2 Truth table ch0 (NA=2,NB=2), OUT_READY=1: A=00,BN=11 -> Y[0]=1; A=01,BN=11 -> 0;
//    A=00,BN=10 -> 0; each one cycle after push, ANY_Y tracks.
//  3 Backpressure: OUT_READY=0, push S1,S2 -> IN_READY=0 after 2nd push; S3 held;
//    raise OUT_READY -> outputs S1,S2,S3 in order, none lost or duplicated.
//  4 Simultaneous push/pop in ONE for 10 cycles -> occupancy stays ONE, 1 result/cycle.
//  5 HITCNT_EN, CNT_W=2: 5 pops with Y[1]=1 -> HIT_CNT[1]=3 (saturated); CNT_CLR with a
//    concurrent hit pop -> 0.
//  6 HITCNT_EN undefined: same stimulus as 5 -> HIT_CNT stays 0, data path identical.

Source files
------------

// File: rtl/scs8hd_norbb_pkg.sv
// Shared types and helpers for the multi-channel NOR-with-inverted-inputs pipeline.
// Optional hit counters are enabled by defining SCS8HD_NORBB_HITCNT_EN.
package scs8hd_norbb_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Channel operands are zero-extended to this width before evaluation.
  localparam int unsigned EVAL_MAX_W = 32;

  // Widest counter whose all-ones saturation value the helper below can produce.
  localparam int unsigned SAT_MAX_W = 32;

  // All-ones value of a w-bit counter, i.e. its saturation point (w <= SAT_MAX_W).
  function automatic logic [SAT_MAX_W-1:0] sat_value(input int unsigned w);
    logic [SAT_MAX_W-1:0] v;
    v = {SAT_MAX_W{1'b0}};
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i < w) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // One channel: NOR of the first na bits of a, AND of the first nb bits of bn.
  function automatic logic norbb_eval(input logic [EVAL_MAX_W-1:0] a,
                                      input logic [EVAL_MAX_W-1:0] bn,
                                      input int unsigned na,
                                      input int unsigned nb);
    logic a_any;
    logic bn_all;
    a_any  = 1'b0;
    bn_all = 1'b1;
    for (int unsigned i = 0; i < EVAL_MAX_W; i++) begin
      if (i < na) begin
        a_any = a_any | a[i];
      end else begin
        a_any = a_any;
      end
      if (i < nb) begin
        bn_all = bn_all & bn[i];
      end else begin
        bn_all = bn_all;
      end
    end
    return ~a_any & bn_all;
  endfunction

endpackage

// File: rtl/scs8hd_norbb_skid.sv
// Generic 2-entry in-order valid/ready skid buffer with registered in_ready/out_valid.
// The head register is cleared when the buffer drains, so out_data is 0 while empty.
module scs8hd_norbb_skid
  import scs8hd_norbb_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         state_r, next_state_s;
  logic [W-1:0] head_r, next_head_s;
  logic [W-1:0] tail_r, next_tail_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         push_s;
  logic         pop_s;

  assign push_s    = in_valid & in_ready_r;
  assign pop_s     = out_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_r;

  // Occupancy next-state and storage steering.
  always_comb begin
    next_state_s = state_r;
    next_head_s  = head_r;
    next_tail_s  = tail_r;
    case (state_r)
      OCC_EMPTY: begin
        if (push_s) begin
          next_head_s  = in_data;
          next_state_s = OCC_ONE;
        end else begin
          next_state_s = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push_s && pop_s) begin
          next_head_s = in_data;
        end else if (push_s) begin
          next_tail_s  = in_data;
          next_state_s = OCC_FULL;
        end else if (pop_s) begin
          next_head_s  = {W{1'b0}};
          next_state_s = OCC_EMPTY;
        end else begin
          next_state_s = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (pop_s) begin
          next_head_s  = tail_r;
          next_tail_s  = {W{1'b0}};
          next_state_s = OCC_ONE;
        end else begin
          next_state_s = OCC_FULL;
        end
      end
      default: begin
        next_head_s  = {W{1'b0}};
        next_tail_s  = {W{1'b0}};
        next_state_s = OCC_EMPTY;
      end
    endcase
  end

  // State, storage and handshake flags; flags are derived from the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= OCC_EMPTY;
      head_r      <= {W{1'b0}};
      tail_r      <= {W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      head_r      <= next_head_s;
      tail_r      <= next_tail_s;
      in_ready_r  <= (next_state_s != OCC_FULL);
      out_valid_r <= (next_state_s != OCC_EMPTY);
    end
  end

endmodule

// File: rtl/scs8hd_norbb_pipe.sv
// CH-channel Y = ~|A & (&BN) evaluated on push and held in a 2-entry skid buffer.
// Define SCS8HD_NORBB_HITCNT_EN to add per-channel saturating hit counters.
module scs8hd_norbb_pipe
  import scs8hd_norbb_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned NA    = 2,
  parameter int unsigned NB    = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [CH*NA-1:0]    A,
  input  logic [CH*NB-1:0]    BN,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [CH-1:0]       Y,
  output logic                ANY_Y,
  input  logic                CNT_CLR,
  output logic [CH*CNT_W-1:0] HIT_CNT
);

  logic [CH-1:0] y_eval_s;
  logic [CH-1:0] head_s;

  // Per-channel evaluation of the incoming sample.
  always_comb begin
    logic [EVAL_MAX_W-1:0] a_ext;
    logic [EVAL_MAX_W-1:0] bn_ext;
    y_eval_s = {CH{1'b0}};
    for (int unsigned c = 0; c < CH; c++) begin
      a_ext            = {EVAL_MAX_W{1'b0}};
      bn_ext           = {EVAL_MAX_W{1'b0}};
      a_ext[NA-1:0]    = A[c*NA +: NA];
      bn_ext[NB-1:0]   = BN[c*NB +: NB];
      y_eval_s[c]      = norbb_eval(a_ext, bn_ext, NA, NB);
    end
  end

  scs8hd_norbb_skid #(.W(CH)) u_skid (
    .clk       (CLK),
    .rst       (RESET),
    .in_valid  (IN_VALID),
    .in_ready  (IN_READY),
    .in_data   (y_eval_s),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .out_data  (head_s)
  );

  assign Y     = head_s;
  assign ANY_Y = |head_s;

`ifdef SCS8HD_NORBB_HITCNT_EN
  localparam logic [SAT_MAX_W-1:0] CNT_SAT_FULL = sat_value(CNT_W);
  localparam logic [CNT_W-1:0]     CNT_SAT      = CNT_SAT_FULL[CNT_W-1:0];
  localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1'b1);

  logic          pop_s;
  logic [CNT_W-1:0] cnt_r [CH];

  assign pop_s = OUT_VALID & OUT_READY;

  // Saturating hit counters; clear wins over a same-edge increment.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned c = 0; c < CH; c++) begin
        cnt_r[c] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        if (CNT_CLR) begin
          cnt_r[c] <= {CNT_W{1'b0}};
        end else if (pop_s && head_s[c] && (cnt_r[c] != CNT_SAT)) begin
          cnt_r[c] <= cnt_r[c] + CNT_ONE;
        end else begin
          cnt_r[c] <= cnt_r[c];
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    HIT_CNT = {(CH*CNT_W){1'b0}};
    for (int unsigned c = 0; c < CH; c++) begin
      HIT_CNT[c*CNT_W +: CNT_W] = cnt_r[c];
    end
  end
`else
  logic unused_cnt_clr_s;

  assign unused_cnt_clr_s = CNT_CLR;
  assign HIT_CNT          = {(CH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_scs8hd_norbb_pipe.sv
// Scoreboard bench for scs8hd_norbb_pipe (CNT_W=2); expectations for HIT_CNT follow
// whether SCS8HD_NORBB_HITCNT_EN is defined in the build.
module tb_scs8hd_norbb_pipe;

  localparam int CH    = 4;
  localparam int NA    = 2;
  localparam int NB    = 2;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic                CLK = 1'b0;
  logic                RESET;
  logic                IN_VALID;
  logic                IN_READY;
  logic [CH*NA-1:0]    A;
  logic [CH*NB-1:0]    BN;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic [CH-1:0]       Y;
  logic                ANY_Y;
  logic                CNT_CLR;
  logic [CH*CNT_W-1:0] HIT_CNT;

  int checks = 0;
  int errors = 0;
  logic [CH-1:0] exp_q[$];
  int cnt_m[CH];

  scs8hd_norbb_pipe #(.CH(CH), .NA(NA), .NB(NB), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .BN(BN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Y(Y), .ANY_Y(ANY_Y), .CNT_CLR(CNT_CLR), .HIT_CNT(HIT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] ref_y(input logic [CH*NA-1:0] a, input logic [CH*NB-1:0] bn);
    logic [CH-1:0] r;
    logic any_a;
    logic all_b;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      any_a = 1'b0;
      all_b = 1'b1;
      for (int i = 0; i < NA; i++) any_a = any_a | a[c*NA+i];
      for (int i = 0; i < NB; i++) all_b = all_b & bn[c*NB+i];
      r[c] = !any_a && all_b;
    end
    return r;
  endfunction

  function automatic logic [CH*CNT_W-1:0] pack_cnt();
    logic [CH*CNT_W-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r[c*CNT_W +: CNT_W] = CNT_W'(cnt_m[c]);
    return r;
  endfunction

  // Checks outputs against the scoreboard, predicts the coming edge, then advances one cycle.
  task automatic step();
    logic [CH-1:0] head;
    bit do_pop;
    bit do_push;
    check("out_valid", OUT_VALID, exp_q.size() > 0);
    check("in_ready", IN_READY, exp_q.size() < 2);
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("y", Y, head);
    check("any_y", ANY_Y, |head);
    do_pop  = (exp_q.size() > 0) && OUT_READY;
    do_push = IN_VALID && (exp_q.size() < 2);
`ifdef SCS8HD_NORBB_HITCNT_EN
    for (int c = 0; c < CH; c++) begin
      if (CNT_CLR) cnt_m[c] = 0;
      else if (do_pop && head[c] && cnt_m[c] < SAT) cnt_m[c] = cnt_m[c] + 1;
    end
`endif
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(ref_y(A, BN));
    @(posedge CLK);
    #1;
    check("hit_cnt", HIT_CNT, pack_cnt());
  endtask

  task automatic drive(input logic [CH*NA-1:0] a, input logic [CH*NB-1:0] bn,
                       input logic v, input logic r);
    A = a;
    BN = bn;
    IN_VALID = v;
    OUT_READY = r;
    step();
  endtask

  initial begin
    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; CNT_CLR = 1'b0;
    A = '0; BN = '0;
    for (int c = 0; c < CH; c++) cnt_m[c] = 0;
    #1;
    check("rst_in_ready", IN_READY, 1'b0);
    check("rst_out_valid", OUT_VALID, 1'b0);
    check("rst_y", Y, '0);
    check("rst_hit", HIT_CNT, '0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hold_in_ready", IN_READY, 1'b0);
    RESET = 1'b0;
    check("rel_in_ready_pre", IN_READY, 1'b0);
    @(posedge CLK);
    #1;
    check("rel_in_ready_post", IN_READY, 1'b1);

    // Truth table on channel 0; other channels held non-hitting.
    drive(8'b0101_0100, 8'b0000_0011, 1'b1, 1'b1);
    check("tt_00_11", Y[0], 1'b1);
    drive(8'b0101_0101, 8'b0000_0011, 1'b1, 1'b1);
    check("tt_01_11", Y[0], 1'b0);
    drive(8'b0101_0100, 8'b0000_0010, 1'b1, 1'b1);
    check("tt_00_10", Y[0], 1'b0);
    drive('0, '0, 1'b0, 1'b1);
    check("tt_drained", OUT_VALID, 1'b0);

    // Backpressure: two pushes fill the buffer, third sample held until space.
    drive(8'h00, 8'hFF, 1'b1, 1'b0);
    drive(8'h10, 8'hF0, 1'b1, 1'b0);
    check("bp_full", IN_READY, 1'b0);
    drive(8'h01, 8'h0F, 1'b1, 1'b0);
    drive(8'h01, 8'h0F, 1'b1, 1'b0);
    drive(8'h01, 8'h0F, 1'b1, 1'b1);
    drive(8'h01, 8'h0F, 1'b1, 1'b1);
    drive('0, '0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b1);
    check("bp_empty_q", exp_q.size(), 0);

    // Streaming in ONE: push and pop every cycle.
    drive(8'h00, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(CH*NA'($urandom_range(0, 255) & $urandom_range(0, 255)),
            CH*NB'($urandom_range(0, 255) | $urandom_range(0, 255)), 1'b1, 1'b1);
      check("one_state_valid", OUT_VALID, 1'b1);
      check("one_state_ready", IN_READY, 1'b1);
    end
    drive('0, '0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b1);

    // Hit counters: clear, five channel-1 hit pops, then clear against a concurrent hit pop.
    CNT_CLR = 1'b1;
    drive('0, '0, 1'b0, 1'b1);
    CNT_CLR = 1'b0;
    for (int i = 0; i < 6; i++) drive(8'h00, 8'hFF, 1'b1, 1'b1);
`ifdef SCS8HD_NORBB_HITCNT_EN
    check("hit1_sat", HIT_CNT[3:2], 2'd3);
`else
    check("hit1_off", HIT_CNT[3:2], 2'd0);
`endif
    CNT_CLR = 1'b1;
    drive('0, '0, 1'b0, 1'b1);
    CNT_CLR = 1'b0;
    check("hit1_clr", HIT_CNT[3:2], 2'd0);

    // Reset mid-stream with two entries held and a non-zero counter.
    drive(8'h00, 8'hFF, 1'b1, 1'b1);
    drive('0, '0, 1'b0, 1'b1);
    drive(8'h00, 8'hFF, 1'b1, 1'b0);
    drive(8'h00, 8'h3F, 1'b1, 1'b0);
    check("pre_rst_full", IN_READY, 1'b0);
    RESET = 1'b1;
    #1;
    check("mid_rst_out_valid", OUT_VALID, 1'b0);
    check("mid_rst_y", Y, '0);
    check("mid_rst_any", ANY_Y, 1'b0);
    check("mid_rst_hit", HIT_CNT, '0);
    check("mid_rst_in_ready", IN_READY, 1'b0);
    exp_q.delete();
    for (int c = 0; c < CH; c++) cnt_m[c] = 0;
    IN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("mid_rel_pre", IN_READY, 1'b0);
    @(posedge CLK);
    #1;
    check("mid_rel_post", IN_READY, 1'b1);
    drive(8'h00, 8'hCF, 1'b1, 1'b1);
    drive('0, '0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
